cpu_trace_capture: RTL

- Synthesizable run-control and register-writeback trace unit for the pipelined CPU; replaces the fixed-length, monitor-only simulation harness.
- Taps the writeback port and PC each cycle and runs for a bounded, parametrised number of cycles.
- Captures each register write as a time-stamped record in an internal FIFO.
- A downstream consumer (bench scoreboard or debug UART) drains the FIFO through a valid/ready handshake.

---
 rtl/cpu_trace_capture.sv | 111 +++++++++++
 1 files changed

// File: rtl/cpu_trace_capture.sv
// Run-control and register-writeback trace unit: time-stamps each register write into a FIFO drained by valid/ready.
// Optional macro TRACE_ADDR_FILTER_EN adds filt_lo/filt_hi to restrict capture to an address window.
module cpu_trace_capture #(
  parameter int PC_W    = 32,
  parameter int AW      = 3,
  parameter int DW      = 16,
  parameter int STAMP_W = 16,
  parameter int DEPTH   = 8,
  localparam int REC_W  = STAMP_W + PC_W + AW + DW
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               stop,
  input  logic [STAMP_W-1:0] cycle_limit,
  input  logic [PC_W-1:0]    pc,
  input  logic               wb_en,
  input  logic [AW-1:0]      wb_addr,
  input  logic [DW-1:0]      wb_data,
  output logic               trace_valid,
  input  logic               trace_ready,
  output logic [REC_W-1:0]   trace_data,
  output logic               busy,
  output logic               done,
  output logic [7:0]         drop_cnt
`ifdef TRACE_ADDR_FILTER_EN
  ,
  input  logic [AW-1:0]      filt_lo,
  input  logic [AW-1:0]      filt_hi
`endif
);

  localparam int PW = $clog2(DEPTH);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

  state_t             state, state_nx;
  logic [STAMP_W-1:0] cnt;
  logic [REC_W-1:0]   mem [DEPTH];
  logic [PW:0]        wptr, rptr;
  logic [REC_W-1:0]   hold_q;

  logic empty, full, pop, push, drop, capture, addr_ok, last_cycle, start_ok;

  // The extra MSB on each pointer tells a full FIFO apart from an empty one.
  assign empty = (wptr == rptr);
  assign full  = (wptr[PW] != rptr[PW]) && (wptr[PW-1:0] == rptr[PW-1:0]);

`ifdef TRACE_ADDR_FILTER_EN
  assign addr_ok = (wb_addr >= filt_lo) && (wb_addr <= filt_hi);
`else
  assign addr_ok = 1'b1;
`endif

  assign trace_valid = !empty;
  assign pop         = trace_valid && trace_ready;
  assign capture     = (state == RUN) && wb_en && addr_ok;
  // A full FIFO still accepts a write when the head leaves in the same cycle.
  assign push        = capture && (!full || pop);
  assign drop        = capture && full && !pop;
  assign last_cycle  = stop || ((cycle_limit != '0) && (cnt == cycle_limit - STAMP_W'(1)));
  assign start_ok    = start && ((state == IDLE) || (state == DONE));

  // Head is read straight from the array; once empty, the last presented record is held.
  assign trace_data = trace_valid ? mem[rptr[PW-1:0]] : hold_q;
  assign busy       = (state == RUN) || (state == DRAIN);
  assign done       = (state == DONE);

  // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE, DONE: if (start) state_nx = RUN;
      RUN:        if (last_cycle) state_nx = DRAIN;
      DRAIN:      if (empty) state_nx = DONE;
      default:    state_nx = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      cnt      <= '0;
      wptr     <= '0;
      rptr     <= '0;
      drop_cnt <= '0;
      hold_q   <= '0;
    end else begin
      state <= state_nx;
      if (trace_valid) hold_q <= mem[rptr[PW-1:0]];
      if (start_ok) begin
        cnt      <= '0;
        wptr     <= '0;
        rptr     <= '0;
        drop_cnt <= '0;
      end else begin
        if (push) wptr <= wptr + (PW+1)'(1);
        if (pop)  rptr <= rptr + (PW+1)'(1);
        if (state == RUN) cnt <= cnt + STAMP_W'(1);
        if (drop && (drop_cnt != 8'hff)) drop_cnt <= drop_cnt + 8'd1;
      end
    end
  end

  // NOTE: the storage array has no reset; the pointers alone define which entries are valid.
  always_ff @(posedge clk) begin
    if (push) mem[wptr[PW-1:0]] <= {cnt, pc, wb_addr, wb_data};
  end

endmodule
